microstore_control_register: RTL and testbench
==============================================

Name: microstore_control_register

Overview:
- Downstream stage of the microsequencer's next-state selection logic.
- Takes the selected 7-bit next-state number and registers it as the current microstate. Latches the microword addressed by that state into the Control Register.
- Returns the sequencing fields (N, S, inv, CR) to the next-state logic and drives datapath and memory control signals.
- The microstore is a writable RAM, loaded through a program port. A memory-wait watchdog forces a fault microstate if MOC never arrives.

Parameters:
- SW, 7, microstate width; the microstore has 2**SW words.
- CW_W, 32, microword width.
- TIMEOUT, 16, consecutive memory-wait cycles before a fault; legal range 2..255.
- FAULT_STATE, 7'd127, microstate forced on timeout.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- state_in  in  SW  next state from the state selector mux.
- stall  in  1  freezes the state register and Control Register.
- moc  in  1  memory operation complete.
- prog_we  in  1  microstore write enable.
- prog_addr  in  SW  microstore write address.
- prog_data  in  CW_W  microstore write data.
- cur_state  out  SW  registered current microstate.
- N  out  3  next-state selector code, bits [2:0] of the Control Register.
- S  out  2  condition mux select, bits [4:3].
- inv  out  1  condition inversion, bit [5].
- CR  out  7  literal next-state field, bits [12:6].
- mem_req  out  1  memory operation valid, bit [13].
- mem_rw  out  1  1 = write, 0 = read, bit [14].
- dp_ctrl  out  17  datapath control lines, bits [31:15].
- inc_ld  out  1  Ld for the incrementer register.
- mem_timeout  out  1  sticky watchdog fault flag.

Behaviour:
- Reset (synchronous):
  - cur_state = 0 and Control Register = 0, so every field output is 0 (N=000 selects the encoder).
  - Watchdog count = 0; mem_timeout = 0.
  - Microstore contents are not cleared.
- Normal load (stall=0, no timeout): on posedge, cur_state <= state_in and CR_reg <= ustore[state_in].
  - Latency: one cycle from state_in to field outputs.
- Stall: cur_state and CR_reg hold.
  - The watchdog count holds and does not advance.
  - inc_ld = ~stall (combinational). inc_ld is 0 while reset is high.
- Microstore write: on posedge with prog_we=1, ustore[prog_addr] <= prog_data.
  - Read-before-write: if prog_addr == state_in on the same edge, CR_reg receives the OLD word.
  - Writes are accepted during stall and during reset.
- Watchdog:
  - A wait cycle is any posedge with mem_req=1, moc=0, stall=0 and reset=0.
  - Each wait cycle increments the count.
  - The count clears on any edge with moc=1 or mem_req=0.
  - On the wait edge where the count == TIMEOUT-1 (the TIMEOUT-th consecutive wait):
    - cur_state <= FAULT_STATE and CR_reg <= ustore[FAULT_STATE]; state_in is ignored.
    - mem_timeout <= 1; count <= 0.
  - moc=1 on that same edge wins: normal load, no fault.
- Priority: reset > timeout force > stall > normal load.
- mem_timeout stays 1 until reset. Later timeouts re-force FAULT_STATE with the flag still set.
- All outputs are registered except inc_ld. No combinational path from state_in to the field outputs.
- Reset mid-wait discards the watchdog count. Reset during stall still clears everything.

Test Plan:
- Load ustore[9] = 32'h0000_1A4B, reset, then drive state_in = 9 -> one cycle later N=011, S=01, inv=0, CR=7'd105, mem_req=0, mem_rw=0, dp_ctrl=0, cur_state=9.
- Same-edge write of ustore[5] = 32'hFFFF_FFFF while state_in = 5 and the old word is 0 -> first output is all zeros; re-selecting 5 on the next cycle gives all ones.
- Hold stall=1 for 3 cycles while state_in changes 3 -> 4 -> 6 -> cur_state and fields stay unchanged and inc_ld = 0; on release, state 6 loads one cycle later.
- ustore[20] = 32'h0000_2000 (mem_req=1), state_in held at 20, moc=0, TIMEOUT=16 -> after 16 wait edges cur_state = 127, fields = ustore[127], mem_timeout = 1 (sticky).
- Same as above but moc=1 on the 16th edge -> no fault, cur_state = 20, mem_timeout = 0, count cleared.
- Assert reset while mem_timeout=1 and cur_state=127 -> the next edge clears all outputs to 0; ustore contents survive, checked by reloading state 9.

Source files
------------

// File: rtl/microstore_control_register.sv
// Microstore RAM plus Control Register stage of the microsequencer.
// Registers the next microstate and its microword, with a memory-wait watchdog.
module microstore_control_register #(
  parameter int unsigned   SW          = 7,
  parameter int unsigned   CW_W        = 32,
  parameter int unsigned   TIMEOUT     = 16,
  parameter logic [SW-1:0] FAULT_STATE = 7'd127
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW-1:0]   state_in,
  input  logic            stall,
  input  logic            moc,
  input  logic            prog_we,
  input  logic [SW-1:0]   prog_addr,
  input  logic [CW_W-1:0] prog_data,
  output logic [SW-1:0]   cur_state,
  output logic [2:0]      N,
  output logic [1:0]      S,
  output logic            inv,
  output logic [6:0]      CR,
  output logic            mem_req,
  output logic            mem_rw,
  output logic [16:0]     dp_ctrl,
  output logic            inc_ld,
  output logic            mem_timeout
);

  localparam int unsigned Depth   = 2 ** SW;
  localparam logic [7:0]  CntLast = 8'(TIMEOUT - 1);

  logic [CW_W-1:0] ustore_q [Depth];

  logic [SW-1:0]   cur_state_q, cur_state_d;
  logic [CW_W-1:0] cr_q, cr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic            wait_cyc, timeout_hit;

  always_comb begin
    wait_cyc      = cr_q[13] & ~moc & ~stall & ~reset;
    timeout_hit   = wait_cyc && (cnt_q == CntLast);
    cur_state_d   = cur_state_q;
    cr_d          = cr_q;
    cnt_d         = cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (timeout_hit) begin
      cur_state_d   = FAULT_STATE;
      cr_d          = ustore_q[FAULT_STATE];
      mem_timeout_d = 1'b1;
      cnt_d         = '0;
    end else begin
      if (!stall) begin
        cur_state_d = state_in;
        // Array read sees the pre-edge contents, so a same-edge write yields the old word.
        cr_d        = ustore_q[state_in];
      end
      if (moc || !cr_q[13]) begin
        cnt_d = '0;
      end else if (wait_cyc) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Microstore is not reset; programming is honoured even during reset and stall.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      ustore_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state_q   <= '0;
      cr_q          <= '0;
      cnt_q         <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      cur_state_q   <= cur_state_d;
      cr_q          <= cr_d;
      cnt_q         <= cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign cur_state   = cur_state_q;
  assign N           = cr_q[2:0];
  assign S           = cr_q[4:3];
  assign inv         = cr_q[5];
  assign CR          = cr_q[12:6];
  assign mem_req     = cr_q[13];
  assign mem_rw      = cr_q[14];
  assign dp_ctrl     = cr_q[31:15];
  assign inc_ld      = ~stall & ~reset;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_microstore_control_register.sv
// Scoreboard bench: the driver queues the expected post-edge state, a monitor checks it.
module tb_microstore_control_register;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  state_in = '0;
  logic        stall = 1'b0;
  logic        moc = 1'b0;
  logic        prog_we = 1'b0;
  logic [6:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [6:0]  cur_state;
  logic [2:0]  N;
  logic [1:0]  S;
  logic        inv;
  logic [6:0]  CR;
  logic        mem_req;
  logic        mem_rw;
  logic [16:0] dp_ctrl;
  logic        inc_ld;
  logic        mem_timeout;

  microstore_control_register dut (
    .clk         (clk),
    .reset       (reset),
    .state_in    (state_in),
    .stall       (stall),
    .moc         (moc),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .cur_state   (cur_state),
    .N           (N),
    .S           (S),
    .inv         (inv),
    .CR          (CR),
    .mem_req     (mem_req),
    .mem_rw      (mem_rw),
    .dp_ctrl     (dp_ctrl),
    .inc_ld      (inc_ld),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] W0   = 32'h0000_0000;
  localparam logic [31:0] W9   = 32'h0000_1A4B;
  localparam logic [31:0] W3   = 32'h1234_0003;
  localparam logic [31:0] W4   = 32'hABCD_0004;
  localparam logic [31:0] W6   = 32'h0F0F_1006;
  localparam logic [31:0] W20  = 32'h0000_2000;
  localparam logic [31:0] W127 = 32'hDEAD_8001;
  localparam logic [31:0] WONE = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [6:0]  cs;
    logic [31:0] w;
    logic        tmo;
    logic        ild;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("cur_state", 32'(cur_state), 32'(e.cs));
      check("fields", {dp_ctrl, mem_rw, mem_req, CR, inv, S, N}, e.w);
      check("mem_timeout", 32'(mem_timeout), 32'(e.tmo));
      check("inc_ld", 32'(inc_ld), 32'(e.ild));
    end
  end

  task automatic cyc(input logic rst, input logic stl, input logic mc, input logic [6:0] st,
                     input logic we, input logic [6:0] pa, input logic [31:0] pd,
                     input logic [6:0] ecs, input logic [31:0] ew, input logic etmo);
    @(negedge clk);
    reset     = rst;
    stall     = stl;
    moc       = mc;
    state_in  = st;
    prog_we   = we;
    prog_addr = pa;
    prog_data = pd;
    q.push_back('{cs: ecs, w: ew, tmo: etmo, ild: ~stl & ~rst});
  endtask

  task automatic run(input logic stl, input logic mc, input logic [6:0] st,
                     input logic [6:0] ecs, input logic [31:0] ew, input logic etmo);
    cyc(1'b0, stl, mc, st, 1'b0, 7'd0, 32'd0, ecs, ew, etmo);
  endtask

  logic [6:0]  pa_t [8] = '{7'd0, 7'd9, 7'd5, 7'd3, 7'd4, 7'd6, 7'd20, 7'd127};
  logic [31:0] pd_t [8] = '{W0, W9, W0, W3, W4, W6, W20, W127};

  initial begin
    // Program the microstore while reset is held; outputs must stay cleared.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 7'd9, 1'b1, pa_t[i], pd_t[i], 7'd0, W0, 1'b0);
    end
    run(1'b0, 1'b0, 7'd0, 7'd0, W0, 1'b0);
    run(1'b0, 1'b0, 7'd9, 7'd9, W9, 1'b0);
    // Same-edge write of the selected state returns the old word first.
    cyc(1'b0, 1'b0, 1'b0, 7'd5, 1'b1, 7'd5, WONE, 7'd5, W0, 1'b0);
    run(1'b0, 1'b1, 7'd5, 7'd5, WONE, 1'b0);
    run(1'b1, 1'b1, 7'd3, 7'd5, WONE, 1'b0);
    run(1'b1, 1'b1, 7'd4, 7'd5, WONE, 1'b0);
    run(1'b1, 1'b1, 7'd6, 7'd5, WONE, 1'b0);
    run(1'b0, 1'b1, 7'd6, 7'd6, W6, 1'b0);
    // Watchdog: 15 waits, moc on the 16th clears the count, then 16 waits fault.
    run(1'b0, 1'b0, 7'd20, 7'd20, W20, 1'b0);
    for (int i = 0; i < 15; i++) run(1'b0, 1'b0, 7'd20, 7'd20, W20, 1'b0);
    run(1'b0, 1'b1, 7'd20, 7'd20, W20, 1'b0);
    for (int i = 0; i < 15; i++) run(1'b0, 1'b0, 7'd20, 7'd20, W20, 1'b0);
    run(1'b0, 1'b0, 7'd20, 7'd127, W127, 1'b1);
    run(1'b0, 1'b0, 7'd9, 7'd9, W9, 1'b1);
    run(1'b0, 1'b0, 7'd127, 7'd127, W127, 1'b1);
    run(1'b1, 1'b0, 7'd3, 7'd127, W127, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 7'd9, 1'b0, 7'd0, 32'd0, 7'd0, W0, 1'b0);
    run(1'b0, 1'b0, 7'd9, 7'd9, W9, 1'b0);
    run(1'b0, 1'b0, 7'd3, 7'd3, W3, 1'b0);
    run(1'b0, 1'b0, 7'd4, 7'd4, W4, 1'b0);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
